alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have these ports: clk input 1, the single clock; it clocks only the flag register.
REQ-002 The module SHALL have rst_n input 1, asynchronous active-low reset.
REQ-003 The module SHALL have alu_opcode input alu_op_t (4 bits), the operation select.
REQ-004 The module SHALL have data_in1 input 32, operand A.
REQ-005 The module SHALL have data_in2 input 32, operand B; bits [4:0] are the shift amount for shift ops.
REQ-006 The module SHALL have flags_we input 1; when high, flags_out is captured into the flag register.
REQ-007 The module SHALL have data_out output 32, the combinational result.
REQ-008 The module SHALL have flags_out output alu_flags_t, the combinational NZCV for the current operation.
REQ-009 The module SHALL have flags_q output alu_flags_t, the registered NZCV (APSR image).

Function
REQ-010 data_out and flags_out SHALL be purely combinational from alu_opcode, data_in1 and data_in2, with zero latency and no dependence on clk.
REQ-011 The opcodes SHALL be ADD=0, SUB=1, AND=2, ORR=3, EOR=4, LSL=5, LSR=6, ASR=7; codes 8-15 are reserved.
REQ-012 ADD SHALL give A+B mod 2^32; C = carry out of bit 31; V = (A[31]==B[31]) and (R[31]!=A[31]).
REQ-013 SUB SHALL give A-B mod 2^32; C = 1 when there is no borrow (A>=B unsigned), ARM convention; V = (A[31]!=B[31]) and (R[31]!=A[31]).
REQ-014 AND, ORR and EOR SHALL give the bitwise result, with C=0 and V=0.
REQ-015 LSL SHALL give A<<sh with sh=B[4:0]; C = A[32-sh] for sh!=0, and C=0 for sh=0; V=0.
REQ-016 LSR SHALL give A>>sh, zero-filled; ASR SHALL give A>>sh, sign-filled from A[31]; for both, C = A[sh-1] for sh!=0, C=0 for sh=0, and V=0.
REQ-017 Shift amounts SHALL use only B[4:0]; B[31:5] are ignored, so a shift amount of 32 or more is not possible.
REQ-018 For all opcodes, N = R[31] and Z = (R==0).
REQ-019 Reserved opcodes SHALL give data_out=32'hFFFFFFFF and flags_out N=1, Z=0, C=0, V=0.
REQ-020 On each rising clk edge with flags_we=1, flags_q SHALL load flags_out; with flags_we=0, flags_q SHALL hold its value.
REQ-021 Any change on the inputs SHALL update data_out and flags_out within the same cycle, with no stale state.

Reset
REQ-022 While rst_n=0, flags_q SHALL be forced to 4'b0000 asynchronously.
REQ-023 data_out and flags_out SHALL be unaffected by reset.
REQ-024 flags_we SHALL be ignored while rst_n=0; the first load occurs on the first rising edge after reset is released.

Structure
REQ-025 Package alu_pkg SHALL hold alu_op_t (a 4-bit enum) and alu_flags_t (a packed struct with fields n, z, c, v, MSB to LSB, i.e. NZCV order).
REQ-026 The barrel shifter (LSL, LSR, ASR, including carry out) SHALL be a sub-module named alu_shifter; the adder/subtractor and logic ops stay in alu.
REQ-027 The result multiplexer and flag generation SHALL be a single combinational block; the only sequential element is flags_q.

Verification
REQ-028 ADD 0x7FFFFFFF+0x1 SHALL give 0x80000000 with NZCV=1001; ADD 0xFFFFFFFF+0x1 SHALL give 0x0 with NZCV=0110.
REQ-029 SUB 0x5-0x5 SHALL give 0x0 with NZCV=0110; SUB 0x0-0x1 SHALL give 0xFFFFFFFF with NZCV=1000; SUB 0x80000000-0x1 SHALL give 0x7FFFFFFF with NZCV=0011.
REQ-030 LSL 0x80000000 by 1 SHALL give 0x0 with NZCV=0110; LSL 0xFFFFFFFF by 0 SHALL give 0xFFFFFFFF with NZCV=1000.
REQ-031 ASR 0x80000000 by 31 SHALL give 0xFFFFFFFF with NZCV=1000; LSR 0x1 by 1 SHALL give 0x0 with NZCV=0110; ASR 0x7FFFFFFF by 1 SHALL give 0x3FFFFFFF with NZCV=0010.
REQ-032 Flag register: assert rst_n low mid-run -> flags_q=0000 immediately; after release, ADD 0xFFFFFFFF+1 with flags_we=1 -> flags_q=0110 after the edge; flags_we=0 with new ops -> flags_q holds.
REQ-033 Random check: at least 1000 random opcode 0-7 and operand triples SHALL match a reference model on both data_out and flags_out.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU: opcode enum, NZCV flag struct and
// shifter control used between the top and the barrel shifter.
package alu_pkg;

   localparam int XLEN = 32;
   localparam int SHW  = 5;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_ORR = 4'd3,
      ALU_EOR = 4'd4,
      ALU_LSL = 4'd5,
      ALU_LSR = 4'd6,
      ALU_ASR = 4'd7
   } alu_op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic [1:0] {
      SH_LSL = 2'd0,
      SH_LSR = 2'd1,
      SH_ASR = 2'd2
   } sh_kind_t;

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] x);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = x[XLEN-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Log-stage barrel shifter for LSL/LSR/ASR with carry out.
// Left shifts reuse the right-shift network on the bit-reversed operand.
module alu_shifter
   import alu_pkg::*;
(
   input  sh_kind_t          kind,
   input  logic [XLEN-1:0]   data_in,
   input  logic [SHW-1:0]    shamt,
   output logic [XLEN-1:0]   res,
   output logic              carry
);

   localparam logic [XLEN:0] ONES = '1;

   logic            fill;
   logic [XLEN-1:0] src;
   logic [XLEN:0]   w;

   // w carries one guard bit below the word; it ends up holding the last bit shifted out
   always_comb begin
      fill = (kind == SH_ASR) & data_in[XLEN-1];
      src  = (kind == SH_LSL) ? bit_rev(data_in) : data_in;
      w    = {src, 1'b0};
      for (int i = 0; i < SHW; i++) begin
         if (shamt[i]) begin
            w = (w >> (1 << i)) | (fill ? ~(ONES >> (1 << i)) : '0);
         end
      end
      res   = (kind == SH_LSL) ? bit_rev(w[XLEN:1]) : w[XLEN:1];
      carry = w[0];
   end

endmodule

// File: rtl/alu.sv
// 32-bit ALU with combinational result/NZCV and a registered
// flag image loaded under flags_we.
module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  alu_op_t           alu_opcode,
   input  logic [XLEN-1:0]   data_in1,
   input  logic [XLEN-1:0]   data_in2,
   input  logic              flags_we,
   output logic [XLEN-1:0]   data_out,
   output alu_flags_t        flags_out,
   output alu_flags_t        flags_q
);

   sh_kind_t        sh_kind;
   logic [XLEN-1:0] sh_res;
   logic            sh_c;
   logic [XLEN-1:0] b_eff;
   logic [XLEN:0]   sum;
   alu_flags_t      flags_d;

   always_comb begin
      case (alu_opcode)
         ALU_LSL: sh_kind = SH_LSL;
         ALU_ASR: sh_kind = SH_ASR;
         default: sh_kind = SH_LSR;
      endcase
   end

   alu_shifter u_shifter (
      .kind    (sh_kind),
      .data_in (data_in1),
      .shamt   (data_in2[SHW-1:0]),
      .res     (sh_res),
      .carry   (sh_c)
   );

   // SUB is A + ~B + 1, so the adder carry is the ARM "no borrow" flag
   always_comb begin
      b_eff     = (alu_opcode == ALU_SUB) ? ~data_in2 : data_in2;
      sum       = {1'b0, data_in1} + {1'b0, b_eff}
                + {{XLEN{1'b0}}, alu_opcode == ALU_SUB};
      data_out  = '1;
      flags_out = '0;
      case (alu_opcode)
         ALU_ADD, ALU_SUB: begin
            data_out    = sum[XLEN-1:0];
            flags_out.c = sum[XLEN];
            flags_out.v = (data_in1[XLEN-1] == b_eff[XLEN-1])
                        & (sum[XLEN-1] != data_in1[XLEN-1]);
         end
         ALU_AND: data_out = data_in1 & data_in2;
         ALU_ORR: data_out = data_in1 | data_in2;
         ALU_EOR: data_out = data_in1 ^ data_in2;
         ALU_LSL, ALU_LSR, ALU_ASR: begin
            data_out    = sh_res;
            flags_out.c = sh_c;
         end
         default: data_out = '1;
      endcase
      flags_out.n = data_out[XLEN-1];
      flags_out.z = (data_out == '0);
   end

   always_comb begin
      flags_d = flags_we ? flags_out : flags_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed vector table, flag-register sequences and a random
// comparison against an independent reference model.
module tb_alu;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   alu_op_t     alu_opcode;
   logic [31:0] data_in1;
   logic [31:0] data_in2;
   logic        flags_we;
   logic [31:0] data_out;
   alu_flags_t  flags_out;
   alu_flags_t  flags_q;

   int errors = 0;
   int checks = 0;

   alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_opcode (alu_opcode),
      .data_in1   (data_in1),
      .data_in2   (data_in2),
      .flags_we   (flags_we),
      .data_out   (data_out),
      .flags_out  (flags_out),
      .flags_q    (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  f;
   } vec_t;

   vec_t vt [26];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b);
      alu_opcode = op;
      data_in1   = a;
      data_in2   = b;
   endtask

   // Reference written straight from the operation definitions
   function automatic logic [35:0] model(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] wide;
      logic [31:0] r;
      logic        c;
      logic        v;
      int          s;
      s = int'(b[4:0]);
      c = 1'b0;
      v = 1'b0;
      r = 32'hFFFF_FFFF;
      case (op)
         4'd0: begin
            wide = {32'd0, a} + {32'd0, b};
            r = wide[31:0];
            c = wide[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd1: begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: begin
            r = a << s;
            c = (s != 0) ? a[32-s] : 1'b0;
         end
         4'd6: begin
            r = a >> s;
            c = (s != 0) ? a[s-1] : 1'b0;
         end
         4'd7: begin
            r = $unsigned($signed(a) >>> s);
            c = (s != 0) ? a[s-1] : 1'b0;
         end
         default: r = 32'hFFFF_FFFF;
      endcase
      return {r, r[31], r == 32'd0, c, v};
   endfunction

   initial begin
      vt[0]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
      vt[1]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      vt[2]  = '{ALU_ADD, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000};
      vt[3]  = '{ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0111};
      vt[4]  = '{ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110};
      vt[5]  = '{ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};
      vt[6]  = '{ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
      vt[7]  = '{ALU_SUB, 32'h0000_0007, 32'h0000_0003, 32'h0000_0004, 4'b0010};
      vt[8]  = '{ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000};
      vt[9]  = '{ALU_AND, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 4'b0100};
      vt[10] = '{ALU_ORR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000};
      vt[11] = '{ALU_EOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100};
      vt[12] = '{ALU_EOR, 32'hAAAA_AAAA, 32'h0000_0000, 32'hAAAA_AAAA, 4'b1000};
      vt[13] = '{ALU_LSL, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      vt[14] = '{ALU_LSL, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000};
      vt[15] = '{ALU_LSL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b1000};
      vt[16] = '{ALU_LSL, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 4'b0000};
      vt[17] = '{ALU_LSR, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      vt[18] = '{ALU_LSR, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000};
      vt[19] = '{ALU_LSR, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 4'b0000};
      vt[20] = '{ALU_ASR, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 4'b1000};
      vt[21] = '{ALU_ASR, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 4'b0010};
      vt[22] = '{ALU_ASR, 32'h8000_0008, 32'h0000_0004, 32'hF800_0000, 4'b1010};
      vt[23] = '{ALU_ASR, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF, 4'b1000};
      vt[24] = '{alu_op_t'(4'd8),  32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};
      vt[25] = '{alu_op_t'(4'd15), 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000};

      // Reset held with flags_we high: flags_q must stay clear
      rst_n    = 1'b0;
      flags_we = 1'b1;
      drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_flags_q", 64'(flags_q), 64'h0);
      chk("reset_data_out", 64'(data_out), 64'h0);
      chk("reset_flags_out", 64'(flags_out), 64'h6);
      @(negedge clk);
      rst_n    = 1'b1;
      flags_we = 1'b0;

      foreach (vt[i]) begin
         drive(vt[i].op, vt[i].a, vt[i].b);
         #1;
         chk($sformatf("vec%0d_data", i), 64'(data_out), 64'(vt[i].r));
         chk($sformatf("vec%0d_nzcv", i), 64'(flags_out), 64'(vt[i].f));
      end

      for (int k = 0; k < 1200; k++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = 4'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (k % 8 == 0) a = 32'h8000_0000 ^ (a & 32'hF);
         drive(alu_op_t'(op), a, b);
         #1;
         chk($sformatf("rand%0d_op%0d", k, op),
             64'({data_out, flags_out}), 64'(model(op, a, b)));
      end

      @(negedge clk);
      flags_we = 1'b1;
      drive(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
      @(posedge clk);
      #1;
      chk("load_add", 64'(flags_q), 64'h6);

      @(negedge clk);
      flags_we = 1'b0;
      drive(ALU_SUB, 32'h0, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      chk("hold_we0", 64'(flags_q), 64'h6);

      @(negedge clk);
      flags_we = 1'b1;
      @(posedge clk);
      #1;
      chk("load_sub", 64'(flags_q), 64'h8);

      // Mid-cycle reset clears immediately, without waiting for an edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clear", 64'(flags_q), 64'h0);
      chk("reset_keeps_data", 64'(data_out), 64'hFFFF_FFFF);
      @(posedge clk);
      #1;
      chk("reset_ignores_we", 64'(flags_q), 64'h0);

      @(negedge clk);
      rst_n = 1'b1;
      drive(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
      @(posedge clk);
      #1;
      chk("first_load_after_reset", 64'(flags_q), 64'h9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
